// File: rtl/rcnum_trajectory_monitor_if.sv
// rcnum_trajectory_monitor_if: monitor bus; master drives start/numIn, slave returns busy/done/status/steps/peak/seed
interface rcnum_trajectory_monitor_if #(
  parameter int WIDTH = 25,
  parameter int STEP_W = 10
);
  logic start;
  logic [WIDTH-1:0] numIn;
  logic busy;
  logic done;
  logic [2:0] status;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0] peak;
  logic [WIDTH-1:0] seed;
  modport master(output start, numIn, input busy, done, status, steps, peak, seed);
  modport slave(input start, numIn, output busy, done, status, steps, peak, seed);
endinterface

// File: rtl/rcnum_trajectory_monitor.sv
// rcnum_trajectory_monitor: follows a 3n+1 trajectory from a latched seed and reports outcome; ports clock, reset (async high), bus (start,numIn in; busy,done,status,steps,peak,seed out)
module rcnum_trajectory_monitor #(
  parameter int WIDTH = 25,
  parameter int STEP_W = 10,
  parameter int MAX_STEPS = 1000
) (
  input logic clock,
  input logic reset,
  rcnum_trajectory_monitor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, TRACK = 2'd1, TERM = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] prev, peak, seed, expected;
  logic [WIDTH+1:0] t;
  logic [STEP_W-1:0] steps, steps_inc;
  logic [2:0] status;
  logic busy, done, mism, fin;
  assign t = {1'b0, prev, 1'b0} + {2'b00, prev} + (WIDTH+2)'(1);
  assign expected = prev[0] ? (|t[WIDTH+1:WIDTH] ? '0 : t[WIDTH-1:0]) : prev >> 1;
  assign mism = bus.numIn != expected;
  assign steps_inc = steps + 1'b1;
  assign fin = bus.numIn <= WIDTH'(1) || steps_inc == STEP_W'(MAX_STEPS);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      peak <= '0;
      seed <= '0;
      steps <= '0;
      status <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (bus.start) begin
      state <= bus.numIn > WIDTH'(1) ? TRACK : TERM;
      status <= bus.numIn == '0 ? 3'd2 : bus.numIn == WIDTH'(1) ? 3'd1 : 3'd0;
      done <= bus.numIn <= WIDTH'(1);
      busy <= bus.numIn > WIDTH'(1);
      seed <= bus.numIn;
      prev <= bus.numIn;
      peak <= bus.numIn;
      steps <= '0;
    end else if (state == TRACK) begin
      if (mism) begin
        state <= TERM;
        status <= 3'd4;
        done <= 1'b1;
        busy <= 1'b0;
      end else begin
        steps <= steps_inc;
        prev <= bus.numIn;
        peak <= bus.numIn > peak ? bus.numIn : peak;
        status <= bus.numIn == WIDTH'(1) ? 3'd1 : bus.numIn == '0 ? 3'd2 : steps_inc == STEP_W'(MAX_STEPS) ? 3'd3 : 3'd0;
        state <= fin ? TERM : TRACK;
        done <= fin;
        busy <= !fin;
      end
    end else
      done <= 1'b0;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.status = status;
  assign bus.steps = steps;
  assign bus.peak = peak;
  assign bus.seed = seed;
endmodule

// File: tb/tb_rcnum_trajectory_monitor.sv
// tb_rcnum_trajectory_monitor: scoreboard bench with two monitors (step budgets 1000 and 5) against a trajectory model
module tb_rcnum_trajectory_monitor;
  localparam int W = 25;
  localparam int SW = 10;
  typedef struct {
    int status;
    int steps;
    longint peak;
    longint seed;
    int busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] num = '0;
  int errors = 0;
  int checks = 0;
  int busy_a = 0;
  int busy_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  always #5 clk = ~clk;
  rcnum_trajectory_monitor_if #(.WIDTH(W), .STEP_W(SW)) ifa ();
  rcnum_trajectory_monitor_if #(.WIDTH(W), .STEP_W(SW)) ifb ();
  assign ifa.start = start;
  assign ifa.numIn = num;
  assign ifb.start = start;
  assign ifb.numIn = num;
  rcnum_trajectory_monitor #(.WIDTH(W), .STEP_W(SW), .MAX_STEPS(1000)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
  rcnum_trajectory_monitor #(.WIDTH(W), .STEP_W(SW), .MAX_STEPS(5)) dut_b (.clock(clk), .reset(rst), .bus(ifb));

  function automatic longint nx(input longint v);
    longint t;
    if (v % 2 == 0) return v / 2;
    t = 3 * v + 1;
    return t >= (longint'(1) << W) ? 0 : t;
  endfunction

  function automatic bit model(input longint s[$], input int max_steps, output exp_t e);
    longint prev;
    e.seed = s[0];
    e.peak = s[0];
    e.steps = 0;
    e.busy = 0;
    e.status = 0;
    if (s[0] == 0) begin e.status = 2; return 1; end
    if (s[0] == 1) begin e.status = 1; return 1; end
    prev = s[0];
    for (int i = 1; i < s.size(); i++) begin
      e.busy++;
      if (s[i] != nx(prev)) begin e.status = 4; return 1; end
      e.steps++;
      prev = s[i];
      if (s[i] > e.peak) e.peak = s[i];
      if (s[i] == 1) begin e.status = 1; return 1; end
      if (s[i] == 0) begin e.status = 2; return 1; end
      if (e.steps == max_steps) begin e.status = 3; return 1; end
    end
    return 0;
  endfunction

  function automatic void collatz(input longint seed, input int maxlen, output longint s[$]);
    s = {};
    s.push_back(seed);
    while (s[$] > 1 && s.size() < maxlen) s.push_back(nx(s[$]));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_run(input string tag, input exp_t e, input longint st, input longint sp, input longint pk, input longint sd, input int bc);
    chk({tag, " status"}, st, e.status);
    chk({tag, " steps"}, sp, e.steps);
    chk({tag, " peak"}, pk, e.peak);
    chk({tag, " seed"}, sd, e.seed);
    chk({tag, " busy cycles"}, bc, e.busy);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (ifa.done) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL A spurious done: done=1 expected 0");
        end else begin
          e = qa.pop_front();
          cmp_run("A", e, ifa.status, ifa.steps, ifa.peak, ifa.seed, busy_a);
        end
      end
      if (ifb.done) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL B spurious done: done=1 expected 0");
        end else begin
          e = qb.pop_front();
          cmp_run("B", e, ifb.status, ifb.steps, ifb.peak, ifb.seed, busy_b);
        end
      end
      if (ifa.busy) busy_a++;
      if (ifb.busy) busy_b++;
      if (start) begin busy_a = 0; busy_b = 0; end
    end
  end

  task automatic drive(input longint s[$]);
    foreach (s[i]) begin
      start = (i == 0);
      num = W'(s[i]);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run(input longint s[$], input int gap);
    exp_t e;
    if (model(s, 1000, e)) qa.push_back(e);
    if (model(s, 5, e)) qb.push_back(e);
    drive(s);
    repeat (gap) begin
      num = W'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " reset busy A"}, ifa.busy, 0);
    chk({tag, " reset done A"}, ifa.done, 0);
    chk({tag, " reset status A"}, ifa.status, 0);
    chk({tag, " reset steps A"}, ifa.steps, 0);
    chk({tag, " reset peak A"}, ifa.peak, 0);
    chk({tag, " reset seed A"}, ifa.seed, 0);
    chk({tag, " reset busy B"}, ifb.busy, 0);
    chk({tag, " reset steps B"}, ifb.steps, 0);
    chk({tag, " reset peak B"}, ifb.peak, 0);
    chk({tag, " reset seed B"}, ifb.seed, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  initial begin
    longint s[$];
    longint seed;
    int k;
    int kind;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("initial");
    rst = 1'b0;
    @(posedge clk);
    #1;
    collatz(6, 1001, s);
    run(s, 3);
    collatz(27, 1001, s);
    run(s, 3);
    collatz(16777217, 1001, s);
    run(s, 3);
    run('{10, 5, 17}, 3);
    run('{1}, 3);
    run('{0}, 3);
    collatz(27, 41, s);
    run(s, 0);
    collatz(6, 1001, s);
    run(s, 3);
    collatz(27, 4, s);
    drive(s);
    #2 rst = 1'b1;
    #1 chk_zero("mid-track");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 2);
      seed = kind == 0 ? longint'($urandom_range(2, 3000)) :
             kind == 1 ? (longint'($urandom_range(0, (1 << 24) - 1)) | (longint'(1) << 24)) :
             longint'($urandom_range(0, 2));
      collatz(seed, 1001, s);
      if ($urandom_range(0, 2) == 0 && s.size() > 1) begin
        k = $urandom_range(1, s.size() - 1);
        s[k] = s[k] ^ (longint'(1) << $urandom_range(0, W - 1));
        while (s.size() > k + 1) void'(s.pop_back());
      end
      run(s, $urandom_range(2, 4));
    end
    repeat (5) @(posedge clk);
    #1;
    chk("A pending expectations", qa.size(), 0);
    chk("B pending expectations", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
